hilo_muldiv_ctrl: RTL
=====================

// Module: hilo_muldiv_ctrl
// PURPOSE
// Sequencer for the iterative multiply/divide unit and the HI/LO registers of the single-cycle core.
// Accepts decoded mult/div/madd/msub/mthi/mtlo ops and runs a radix-2 shift-add multiply or restoring divide.
// Owns HI/LO and raises stall to freeze PC/regfile while a result is pending.
// Sits beside the ALU, driven by the main decoder's muldiv op field.
// PARAMETERS
// WIDTH      32   operand / HI / LO width; iteration count of RUN equals WIDTH
// PORTS
// clk        in   1      core clock, all state on rising edge
// rst_n      in   1      asynchronous, active-low reset
// op_valid   in   1      current instruction is a muldiv/mthi/mtlo op
// op_code    in   4      MULT=1 MULTU=2 DIV=3 DIVU=4 MADD=5 MADDU=6 MSUB=7 MSUBU=8 MTHI=9 MTLO=10; others = no-op
// rs_val     in   WIDTH  operand A / dividend / mthi-mtlo source
// rt_val     in   WIDTH  operand B / divisor
// mf_req     in   1      current instruction reads HI or LO (mfhi/mflo)
// stall      out  1      combinational: freeze PC and regfile write this cycle
// busy       out  1      registered: iterative op in flight
// done       out  1      registered one-cycle pulse: new HI/LO visible this cycle
// hi         out  WIDTH  HI register
// lo         out  WIDTH  LO register
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, hi=lo=0, busy=0, done=0, all iteration regs 0; stall=0. Takes effect mid-operation, op discarded.
// - FSM: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE. No other states.
// - Accept: op_valid && IDLE && op_code in 1..8 at edge E0 -> latch rs/rt, op, sign flags; busy=1; enter RUN.
// - Operands are latched; rs_val/rt_val may change after E0 without effect.
// - RUN: one multiply (shift-add) or restoring-divide step per cycle on unsigned magnitudes.
// - FIX: sign correction and accumulate; hi/lo written, done=1, busy=0 at edge E0+WIDTH+1; back to IDLE.
// - MTHI/MTLO in IDLE: hi or lo <= rs_val at next edge, no busy, no done.
// - Signed ops use magnitudes: product negated (2*WIDTH bits) if signs differ.
// - Signed quotient negated if signs differ; remainder takes dividend sign.
// - Result mapping: MULT(U): {hi,lo}=product. DIV(U): lo=quotient, hi=remainder.
// - MADD(U)/MSUB(U): {hi,lo} = {hi,lo} +/- product, modulo 2^(2*WIDTH); signedness only affects the product.
// - Divide by zero: no trap, full latency, lo=all ones, hi=dividend (signed: sign fix applied to the magnitudes).
// - Signed INT_MIN / -1: lo=INT_MIN (0x80000000), hi=0.
// - stall = (state!=IDLE) && (mf_req || (op_valid && op_code in 1..10)).
// - Held instruction is re-presented and accepted in the first IDLE cycle (the done cycle).
// - mf_req in the done cycle sees the new hi/lo with no stall.
// - op_valid with op_code 0 or 11..15: ignored, no stall, no state change.
// STRUCTURE
// - Package muldiv_pkg: op_code localparams, FSM state encoding, default WIDTH.
// - One sub-module muldiv_iter_core: per-cycle shift-add / restoring-subtract step.
//   Holds accumulator, quotient and counter; exposes start, step, and a last-iteration flag.
// - FSM, sign handling, accumulate and HI/LO registers live in this top.
// TESTING
// 1. rst_n low then release -> hi=lo=0, busy=0, done=0, stall=0; MTLO rs=0x12345678 -> lo=0x12345678 next cycle, busy stays 0.
// 2. MULT rs=0xFFFFFFFE rt=3 -> after 33 cycles hi=0xFFFFFFFF lo=0xFFFFFFFA, done high exactly 1 cycle.
//    MULTU same operands -> hi=0x00000002 lo=0xFFFFFFFA.
// 3. DIV rs=0xFFFFFFF9 rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//    DIVU rs=7 rt=0 -> lo=0xFFFFFFFF hi=7.
//    DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000 hi=0.
// 4. MTHI 0, MTLO 0xFFFFFFFF, MADD rs=1 rt=1 -> hi=1 lo=0.
//    From hi=lo=0, MSUBU rs=1 rt=1 -> hi=lo=0xFFFFFFFF.
// 5. mf_req held high from E0+1 -> stall=1 every cycle through FIX, stall=0 in done cycle with new lo readable.
//    Second MULT held during busy is accepted in the done cycle and completes 33 cycles later.
// 6. rst_n pulsed low at cycle 10 of a DIV -> hi=lo=0, busy=0 immediately, no done pulse.
//    A following MULTU rs=5 rt=6 -> lo=30 hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and default datapath width for the HI/LO multiply/divide
// sequencer.
package muldiv_pkg;

   localparam int unsigned DefWidth = 32;

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMadd  = 4'd5;
   localparam logic [3:0] OpMaddu = 4'd6;
   localparam logic [3:0] OpMsub  = 4'd7;
   localparam logic [3:0] OpMsubu = 4'd8;
   localparam logic [3:0] OpMthi  = 4'd9;
   localparam logic [3:0] OpMtlo  = 4'd10;

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 iteration per step on unsigned magnitudes: shift-add multiply or restoring divide.
// After WIDTH steps {acc_hi,acc_lo} holds the product, or remainder/quotient for a divide.
module muldiv_iter_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] acc_hi,
   output logic [WIDTH-1:0] acc_lo
);

   localparam int unsigned CntW = $clog2(WIDTH);

   logic [WIDTH-1:0] hi_q, lo_q, b_q;
   logic             div_q;
   logic [CntW-1:0]  cnt_q;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] sub;
   logic             ge;

   always_comb begin
      sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
      shifted = {hi_q, lo_q[WIDTH-1]};
      ge      = shifted >= {1'b0, b_q};
      // When ge holds the true difference is below 2^WIDTH, so a WIDTH-bit subtract suffices.
      sub     = shifted[WIDTH-1:0] - b_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else if (start) begin
         hi_q  <= '0;
         lo_q  <= a;
         b_q   <= b;
         div_q <= is_div;
         cnt_q <= '0;
      end else if (step) begin
         if (div_q) begin
            hi_q <= ge ? sub : shifted[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], ge};
         end else begin
            hi_q <= sum[WIDTH:1];
            lo_q <= {sum[0], lo_q[WIDTH-1:1]};
         end
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign last   = (cnt_q == CntW'(WIDTH - 1));
   assign acc_hi = hi_q;
   assign acc_lo = lo_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and sequencer for the iterative multiply/divide unit; stalls the core while a
// result is pending.
module hilo_muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [3:0]       op_code,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mf_req,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t           state_q, state_d;
   logic [3:0]       op_q;
   logic             neg_prod_q, neg_rem_q;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             busy_q, done_q;

   logic             is_arith, is_any, is_signed, is_div, accept, step_en, last;
   logic             rs_neg, rt_neg;
   logic [WIDTH-1:0] mag_a, mag_b, acc_hi, acc_lo, quo, rem;
   logic [2*WIDTH-1:0] prod, result;

   always_comb begin
      is_arith  = (op_code >= OpMult) && (op_code <= OpMsubu);
      is_any    = (op_code >= OpMult) && (op_code <= OpMtlo);
      is_signed = (op_code == OpMult) || (op_code == OpDiv) ||
                  (op_code == OpMadd) || (op_code == OpMsub);
      is_div    = (op_code == OpDiv) || (op_code == OpDivu);
      rs_neg    = is_signed & rs_val[WIDTH-1];
      rt_neg    = is_signed & rt_val[WIDTH-1];
      mag_a     = rs_neg ? -rs_val : rs_val;
      mag_b     = rt_neg ? -rt_val : rt_val;
      accept    = op_valid && is_arith && (state_q == StIdle);
      step_en   = (state_q == StRun);
   end

   muldiv_iter_core #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (accept),
      .step   (step_en),
      .is_div (is_div),
      .a      (mag_a),
      .b      (mag_b),
      .last   (last),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo)
   );

   // Sign fix-up: the quotient shares the product's sign rule, the remainder follows the dividend.
   always_comb begin
      prod = neg_prod_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      quo  = neg_prod_q ? -acc_lo : acc_lo;
      rem  = neg_rem_q ? -acc_hi : acc_hi;
      case (op_q)
         OpMadd, OpMaddu: result = {hi_q, lo_q} + prod;
         OpMsub, OpMsubu: result = {hi_q, lo_q} - prod;
         OpDiv, OpDivu:   result = {rem, quo};
         default:         result = prod;
      endcase
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StRun;
            end else if (op_valid && (op_code == OpMthi)) begin
               hi_d = rs_val;
            end else if (op_valid && (op_code == OpMtlo)) begin
               lo_d = rs_val;
            end
         end
         StRun: begin
            if (last) state_d = StFix;
         end
         StFix: begin
            state_d      = StIdle;
            {hi_d, lo_d} = result;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         op_q       <= '0;
         neg_prod_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= (state_d != StIdle);
         done_q  <= (state_q == StFix);
         if (accept) begin
            op_q       <= op_code;
            neg_prod_q <= rs_neg ^ rt_neg;
            neg_rem_q  <= rs_neg;
         end
      end
   end

   assign stall = (state_q != StIdle) && (mf_req || (op_valid && is_any));
   assign busy  = busy_q;
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
